fixed_point_iterative_mac: RTL and testbench

Streaming fixed-point multiply-accumulate stage that takes operand pairs over a val/rdy interface. It multiplies each pair through a `fixed_point_combinational_Multiplier` instance and sums `len` consecutive products into one accumulated result. It sits directly downstream of that multiplier and is the dot-product/FIR-tap building block for the FFT and filter datapaths. Each completed sum is presented on a val/rdy output.

---
 rtl/fixed_point_pkg.sv | 18 +
 rtl/fixed_point_combinational_Multiplier.sv | 36 +++
 rtl/fixed_point_iterative_mac.sv | 92 +++++++++
 tb/tb_fixed_point_iterative_mac.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point datapath blocks: the accumulate/emit
// state encoding and the sizing helper for term counters.
package fixed_point_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } mac_state_e;

    // A counter that must hold values 0..len needs $clog2(len+1) bits.
    function automatic int count_width(input int len);
        if (len < 1) begin
            return 1;
        end
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/fixed_point_combinational_Multiplier.sv
// Purely combinational Q(n-d).d multiplier: full 2n-bit product, then the n-bit
// window [n+d-1:d] is kept, so out-of-range results wrap.
module fixed_point_combinational_Multiplier #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter bit sign = 1'b1
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    output logic [n-1:0] o_c
);

    logic [2*n-1:0] w_a_ext;
    logic [2*n-1:0] w_b_ext;
    logic [2*n-1:0] w_full;
    logic [2*n-1:0] w_shifted;
    logic           w_unused_high;

    // Extending to 2n bits first makes the low 2n bits of the product exact
    // for both signed and unsigned operands.
    always_comb begin
        if (sign) begin
            w_a_ext = {{n{i_a[n-1]}}, i_a};
            w_b_ext = {{n{i_b[n-1]}}, i_b};
        end else begin
            w_a_ext = {{n{1'b0}}, i_a};
            w_b_ext = {{n{1'b0}}, i_b};
        end
    end

    assign w_full        = w_a_ext * w_b_ext;
    assign w_shifted     = w_full >> d;
    assign o_c           = w_shifted[n-1:0];
    assign w_unused_high = ^w_shifted[2*n-1:n];

endmodule

// File: rtl/fixed_point_iterative_mac.sv
// Streaming multiply-accumulate: sums len consecutive fixed-point products and
// hands each sum out on a val/rdy port before accepting the next group.
module fixed_point_iterative_mac
    import fixed_point_pkg::*;
#(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter bit sign = 1'b1,
    parameter int len  = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] c,
    output logic         o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where val && rdy.
    // recv_rdy is high only in ST_ACC and send_val only in ST_DONE, so the two
    // ports never transfer in the same cycle.

    localparam int               CW   = count_width(len);
    localparam logic [CW-1:0]    LAST = CW'(len - 1);

    mac_state_e    r_state;
    mac_state_e    w_next_state;
    logic [CW-1:0] r_count;
    logic [n-1:0]  r_acc;
    logic [n-1:0]  w_p;
    logic          w_recv_fire;
    logic          w_last_term;

    fixed_point_combinational_Multiplier #(
        .n    (n),
        .d    (d),
        .sign (sign)
    ) u_mult (
        .i_a (a),
        .i_b (b),
        .o_c (w_p)
    );

    assign w_recv_fire = recv_val && recv_rdy;
    assign w_last_term = (r_count == LAST);

    always_comb begin
        w_next_state = r_state;
        recv_rdy     = 1'b0;
        send_val     = 1'b0;
        case (r_state)
            ST_ACC: begin
                recv_rdy = 1'b1;
                if (recv_val && w_last_term) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                send_val = 1'b1;
                if (send_rdy) begin
                    w_next_state = ST_ACC;
                end
            end
            default: begin
                w_next_state = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ACC;
            r_count <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_recv_fire) begin
                // Term 0 overwrites whatever the previous group left behind.
                r_acc   <= (r_count == '0) ? w_p : (r_acc + w_p);
                r_count <= w_last_term ? '0 : (r_count + 1'b1);
            end
        end
    end

    assign c           = r_acc;
    assign o_dbg_state = (r_state == ST_DONE);

endmodule

// File: tb/tb_fixed_point_iterative_mac.sv
// Bench for fixed_point_iterative_mac: four instances (len 1/4/2 signed, len 2
// unsigned) driven with directed and random pairs, scored against a model.
module tb_fixed_point_iterative_mac;

    localparam int N = 32;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   recv_val;
    logic [3:0]   recv_rdy;
    logic [3:0]   send_val;
    logic [3:0]   send_rdy = 4'b0;
    logic [3:0]   dbg_state;
    logic [N-1:0] a_i [4];
    logic [N-1:0] b_i [4];
    logic [N-1:0] c_o [4];

    always #5 clk = ~clk;

    fixed_point_iterative_mac #(.n(N), .d(D), .sign(1'b1), .len(1)) u_len1 (
        .clk(clk), .reset(reset), .recv_val(recv_val[0]), .recv_rdy(recv_rdy[0]),
        .a(a_i[0]), .b(b_i[0]), .send_val(send_val[0]), .send_rdy(send_rdy[0]),
        .c(c_o[0]), .o_dbg_state(dbg_state[0]));
    fixed_point_iterative_mac #(.n(N), .d(D), .sign(1'b1), .len(4)) u_len4 (
        .clk(clk), .reset(reset), .recv_val(recv_val[1]), .recv_rdy(recv_rdy[1]),
        .a(a_i[1]), .b(b_i[1]), .send_val(send_val[1]), .send_rdy(send_rdy[1]),
        .c(c_o[1]), .o_dbg_state(dbg_state[1]));
    fixed_point_iterative_mac #(.n(N), .d(D), .sign(1'b1), .len(2)) u_len2 (
        .clk(clk), .reset(reset), .recv_val(recv_val[2]), .recv_rdy(recv_rdy[2]),
        .a(a_i[2]), .b(b_i[2]), .send_val(send_val[2]), .send_rdy(send_rdy[2]),
        .c(c_o[2]), .o_dbg_state(dbg_state[2]));
    fixed_point_iterative_mac #(.n(N), .d(D), .sign(1'b0), .len(2)) u_uns2 (
        .clk(clk), .reset(reset), .recv_val(recv_val[3]), .recv_rdy(recv_rdy[3]),
        .a(a_i[3]), .b(b_i[3]), .send_val(send_val[3]), .send_rdy(send_rdy[3]),
        .c(c_o[3]), .o_dbg_state(dbg_state[3]));

    int           total = 0;
    int           bad   = 0;
    logic [N-1:0] exp_q [$];
    int           exp_k [$];

    int           m_len [4] = '{1, 4, 2, 2};
    bit           m_sgn [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int           m_terms [4];
    logic [N-1:0] m_sum [4];

    bit           auto_rdy = 1'b1;
    logic [3:0]   man_rdy  = 4'b0;
    int           last_wait;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact real-valued product scaled by 2^D, truncated, wrapped to N bits.
    function automatic logic [N-1:0] ref_prod(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input bit sgn);
        longint          sp;
        longint unsigned up;
        if (sgn) begin
            sp = longint'($signed(x)) * longint'($signed(y));
            sp = sp >>> D;
            return sp[N-1:0];
        end
        up = {32'b0, x} * {32'b0, y};
        up = up >> D;
        return up[N-1:0];
    endfunction

    function automatic bit model_accept(input int k, input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] p;
        p = ref_prod(x, y, m_sgn[k]);
        m_sum[k] = (m_terms[k] == 0) ? p : m_sum[k] + p;
        m_terms[k]++;
        if (m_terms[k] == m_len[k]) begin
            exp_q.push_back(m_sum[k]);
            exp_k.push_back(k);
            m_terms[k] = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Consumer back-pressure, applied later in the cycle than the driver so
    // man_rdy written at +1 is always the value taken.
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < 4; k++) begin
            send_rdy[k] = auto_rdy ? ($urandom_range(0, 3) != 0) : man_rdy[k];
        end
    end

    // Monitor: every result transfer is matched to the oldest expectation of that instance.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("excl%0d", k), {31'b0, recv_rdy[k] & send_val[k]}, '0);
                if (send_val[k] && send_rdy[k]) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < exp_k.size(); i++) begin
                        if (idx < 0 && exp_k[i] == k) idx = i;
                    end
                    if (idx < 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result%0d: got %h expected none", k, c_o[k]);
                    end else begin
                        check($sformatf("result%0d", k), c_o[k], exp_q[idx]);
                        exp_q.delete(idx);
                        exp_k.delete(idx);
                    end
                end
            end
        end
    end

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input int k, input logic [N-1:0] x, input logic [N-1:0] y);
        bit got;
        bit fin;
        got = 1'b0;
        a_i[k] = x;
        b_i[k] = y;
        recv_val[k] = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (recv_rdy[k]) begin
                @(posedge clk);
                #1;
                got = 1'b1;
                last_wait = t;
            end
        end
        recv_val[k] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout%0d: got no handshake expected one within 100 cycles", k);
        end else begin
            fin = model_accept(k, x, y);
            check($sformatf("send_val_after_term%0d", k), {31'b0, send_val[k]}, {31'b0, fin});
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && exp_q.size() > 0; t++) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) m_terms[k] = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_recv_rdy%0d", k), {31'b0, recv_rdy[k]}, 32'd1);
            check($sformatf("rst_send_val%0d", k), {31'b0, send_val[k]}, 32'd0);
            check($sformatf("rst_c%0d", k), c_o[k], 32'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        recv_val = 4'b0;
        for (int k = 0; k < 4; k++) begin
            a_i[k] = '0;
            b_i[k] = '0;
            m_terms[k] = 0;
            m_sum[k] = '0;
        end
        @(posedge clk);
        #1;
        reset_pulse();
        idle(1);

        // Single term, 1.5 * 2.0
        send_pair(0, 32'h0001_8000, 32'h0002_0000);

        // Dot product 1 + 1 - 3 + 1, back to back
        send_pair(1, 32'h0001_0000, 32'h0001_0000);
        check("b2b_wait0", last_wait, 0);
        send_pair(1, 32'h0002_0000, 32'h0000_8000);
        check("b2b_wait1", last_wait, 0);
        send_pair(1, 32'hFFFF_0000, 32'h0003_0000);
        check("b2b_wait2", last_wait, 0);
        send_pair(1, 32'h0000_4000, 32'h0004_0000);
        check("b2b_wait3", last_wait, 0);
        check("done_blocks_input", {31'b0, recv_rdy[1]}, 32'd0);
        wait_drain();

        // Back-pressure on len=2
        auto_rdy = 1'b0;
        man_rdy  = 4'b0;
        idle(1);
        send_pair(2, 32'h0001_0000, 32'h0001_0000);
        send_pair(2, 32'h0001_0000, 32'h0001_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_send_val", {31'b0, send_val[2]}, 32'd1);
            check("bp_recv_rdy", {31'b0, recv_rdy[2]}, 32'd0);
            check("bp_c", c_o[2], 32'h0002_0000);
        end
        @(posedge clk);
        #1;
        man_rdy[2] = 1'b1;
        @(posedge clk);
        #1;
        man_rdy[2] = 1'b0;
        check("bp_reenter_acc", {31'b0, recv_rdy[2]}, 32'd1);
        check("bp_send_val_low", {31'b0, send_val[2]}, 32'd0);
        auto_rdy = 1'b1;
        idle(1);

        // Wrap without saturation
        send_pair(0, 32'h7FFF_0000, 32'h0002_0000);
        send_pair(2, 32'h7FFF_0000, 32'h0001_0000);
        send_pair(2, 32'h7FFF_0000, 32'h0001_0000);
        wait_drain();

        // Reset in the middle of a group drops the partial sum
        send_pair(1, 32'h0003_0000, 32'h0001_0000);
        send_pair(1, 32'h0003_0000, 32'h0001_0000);
        reset_pulse();
        for (int i = 0; i < 4; i++) send_pair(1, 32'h0001_0000, 32'h0001_0000);
        wait_drain();

        // Unsigned with gaps between terms
        send_pair(3, 32'hFFFF_0000, 32'h0001_0000);
        idle(3);
        check("gap_no_advance", {31'b0, send_val[3]}, 32'd0);
        check("gap_still_ready", {31'b0, recv_rdy[3]}, 32'd1);
        send_pair(3, 32'h0001_0000, 32'h0001_0000);
        wait_drain();

        // Random traffic across all instances
        for (int it = 0; it < 200; it++) begin
            int          k;
            logic [N-1:0] x;
            logic [N-1:0] y;
            k = $urandom_range(0, 3);
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                x = {{8{x[23]}}, x[23:0]};
                y = {{8{y[23]}}, y[23:0]};
            end
            send_pair(k, x, y);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
